inst_decode_unit: RTL
=====================

// Module: inst_decode_unit
// PURPOSE
//  Instruction register and decoder feeding the multi-cycle control FSM.
//  Captures the instruction-ROM word on load_inst and decodes it on dec_en.
//  Registers the execution code, register addresses and immediates the control/ALU path consumes.
//  Flags any unsupported encoding.
// PARAMETERS
//  XLEN             32  datapath / instruction width
//  RA_W             5   register-file address width
//  HALT_ON_ILLEGAL  1   1: an illegal word decodes to the HALT code; 0: it decodes to 11'b0
// PORTS
//  clk        in   1     clock; all state changes on rising edge
//  rst        in   1     reset, asynchronous, active-high
//  load_inst  in   1     capture inst_in into IR this edge
//  dec_en     in   1     decode IR into output registers this edge
//  inst_in    in   XLEN  word from instruction ROM at current PC
//  execution  out  11    execution code to control FSM
//  rs1,rs2,rd out  RA_W  register-file addresses
//  imm        out  XLEN  ALU second-operand immediate (ALU_data2)
//  pc_offset  out  XLEN  byte offset for BEQ/JAL to PC unit
//  dec_valid  out  1     outputs hold a decode of the current IR
//  illegal    out  1     sticky: an unsupported word was decoded
// BEHAVIOUR
//  Reset values: IR=0, execution=0, rs1=rs2=rd=0, imm=0, pc_offset=0, dec_valid=0, illegal=0, state=IDLE.
//  Reset is asynchronous. Reset mid-decode discards everything, with no partial update.
//  Edge with load_inst=1: IR<=inst_in.
//  Edge with dec_en=1: all outputs <= decode(IR as it was before the edge); dec_valid<=1.
//    Latency is one edge: outputs are stable in the cycle after dec_en. The control state reads them.
//  load_inst=1 and dec_en=1 on the same edge: decode uses the old IR, and IR takes inst_in.
//  load_inst=1 and dec_en=0: dec_valid<=0, because the outputs no longer match the IR.
//  Neither asserted: every register holds.
//  FSM: IDLE -(load_inst)-> LOADED -(dec_en)-> DECODED -(load_inst)-> LOADED.
//    dec_en in IDLE decodes IR=0, which is illegal.
//  Execution codes (one per instruction, matching the control FSM):
//    LW=001  SLLI=002  SW=004  BEQ=008  ADD=010  SUB=020  SLL=040  XOR=080
//    OR=100  AND=003  JAL=200  HALT=400   (11-bit hex)
//  Matching (opcode / funct3 / funct7):
//    LW    0000011/010
//    SLLI  0010011/001, inst[31:26]=0
//    SW    0100011/010
//    BEQ   1100011/000
//    R-type 0110011, funct7=0:  ADD 000, SLL 001, XOR 100, OR 110, AND 111
//    R-type 0110011, funct7=0100000: SUB 000
//    JAL   1101111
//    HALT  exact word 32'h00100073
//  Any other word: illegal<=1 (sticky until rst), execution per HALT_ON_ILLEGAL, other fields 0.
//  Register fields, zeroed when the format lacks them:
//    rs1=IR[19:15] for I/S/B/R
//    rs2=IR[24:20] for S/B/R
//    rd=IR[11:7]   for I/R/JAL
//  imm:
//    LW      sext(IR[31:20])
//    SLLI    zext(IR[25:20])
//    SW      sext({IR[31:25],IR[11:7]})
//    R-type, BEQ, JAL, HALT: 0
//  pc_offset:
//    BEQ  sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0})
//    JAL  sext({IR[31],IR[19:12],IR[20],IR[30:21],1'b0})
//    all others: 0
// STRUCTURE
//  Shared package riscv_ms_pkg holds the execution-code constants and the opcode/funct3/funct7 constants.
//  The control FSM imports the same package.
//  Sub-module ms_imm_gen is combinational: IR in, imm and pc_offset out.
//  This module holds IR, the FSM, the match logic and the output registers.
// TESTING
//  load 32'h00812183 (lw x3,8(x2)), then dec_en
//    -> exec=11'h001, rs1=2, rd=3, rs2=0, imm=8, dec_valid=1
//  load 32'hFE000AE3 (beq x0,x0,-12)
//    -> exec=11'h008, rs1=0, rs2=0, rd=0, pc_offset=32'hFFFFFFF4, imm=0
//  load 32'h4020_81B3 (sub x3,x1,x2)
//    -> exec=11'h020
//  then 32'h0020_F1B3 (and x3,x1,x2)
//    -> exec=11'h003
//  then 32'h0080_006F (jal x0,8)
//    -> exec=11'h200, rd=0, pc_offset=8
//  load 32'hFFFFFFFF, dec_en
//    -> illegal=1, exec=11'h400
//  then a valid ADD: illegal stays 1
//  rst pulse mid-cycle, asynchronous: all outputs 0 immediately
//  dec_en with no prior load: illegal=1
//  load_inst and dec_en on the same edge: outputs decode the previous IR

Source files
------------

// File: rtl/riscv_ms_pkg.sv
// Package: riscv_ms_pkg
// Purpose: Constants shared by the instruction decoder and the multi-cycle
//          control FSM. It holds the one-per-instruction execution codes,
//          the opcode/funct3/funct7 encodings of the supported subset, and
//          the decoder state type.
// Ports:   none (package)
package riscv_ms_pkg;

  // Execution codes. The control FSM keys on these exact values.
  localparam logic [10:0] EXEC_NONE = 11'h000;
  localparam logic [10:0] EXEC_LW   = 11'h001;
  localparam logic [10:0] EXEC_SLLI = 11'h002;
  localparam logic [10:0] EXEC_AND  = 11'h003;
  localparam logic [10:0] EXEC_SW   = 11'h004;
  localparam logic [10:0] EXEC_BEQ  = 11'h008;
  localparam logic [10:0] EXEC_ADD  = 11'h010;
  localparam logic [10:0] EXEC_SUB  = 11'h020;
  localparam logic [10:0] EXEC_SLL  = 11'h040;
  localparam logic [10:0] EXEC_XOR  = 11'h080;
  localparam logic [10:0] EXEC_OR   = 11'h100;
  localparam logic [10:0] EXEC_JAL  = 11'h200;
  localparam logic [10:0] EXEC_HALT = 11'h400;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 values
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SLLI    = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // The only SYSTEM word accepted; it stops the machine.
  localparam logic [31:0] HALT_WORD = 32'h00100073;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADED,
    ST_DECODED
  } dec_state_e;

endpackage

// File: rtl/ms_imm_gen.sv
// Module: ms_imm_gen
// Purpose: Combinational immediate generator. Builds the ALU immediate and
//          the PC-relative offset from the instruction register contents.
//          Encodings that carry no immediate produce zero. Illegal encodings
//          that share a supported opcode/funct3 are masked by the parent.
// Ports:
//   ir        in   XLEN  instruction register
//   imm       out  XLEN  ALU second-operand immediate
//   pc_offset out  XLEN  byte offset for BEQ/JAL
module ms_imm_gen
  import riscv_ms_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_offset
);

  logic [12:0] b_off;
  logic [20:0] j_off;

  always_comb begin
    imm       = '0;
    pc_offset = '0;
    // Branch/jump offsets are scrambled in the encoding; bit 0 is implicit zero.
    b_off = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    j_off = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    case (ir[6:0])
      OPC_LOAD:
        if (ir[14:12] == F3_LW)
          imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      OPC_OP_IMM:
        if (ir[14:12] == F3_SLLI)
          imm = {{(XLEN-6){1'b0}}, ir[25:20]};
      OPC_STORE:
        if (ir[14:12] == F3_SW)
          imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:
        if (ir[14:12] == F3_BEQ)
          pc_offset = {{(XLEN-13){b_off[12]}}, b_off};
      OPC_JAL:
        pc_offset = {{(XLEN-21){j_off[20]}}, j_off};
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_decode_unit.sv
// Module: inst_decode_unit
// Purpose: Instruction register and decoder in front of the multi-cycle
//          control FSM. It captures the ROM word on load_inst and decodes
//          the held word on dec_en into registered outputs. Unsupported
//          words set a sticky illegal flag.
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   load_inst  in   1     capture inst_in into IR
//   dec_en     in   1     decode IR (pre-edge value) into the outputs
//   inst_in    in   XLEN  instruction ROM word
//   execution  out  11    execution code
//   rs1/rs2/rd out  RA_W  register-file addresses
//   imm        out  XLEN  ALU immediate
//   pc_offset  out  XLEN  BEQ/JAL byte offset
//   dec_valid  out  1     outputs hold a decode of the current IR
//   illegal    out  1     sticky unsupported-encoding flag
module inst_decode_unit
  import riscv_ms_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int RA_W            = 5,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_inst,
  input  logic            dec_en,
  input  logic [XLEN-1:0] inst_in,
  output logic [10:0]     execution,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic [RA_W-1:0] rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_offset,
  output logic            dec_valid,
  output logic            illegal
);

  logic [XLEN-1:0] ir;
  dec_state_e      state, state_nxt;

  logic [10:0]     dec_exec;
  logic            dec_illegal;
  logic            use_rs1, use_rs2, use_rd;
  logic [XLEN-1:0] gen_imm, gen_pc_offset;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ir <= '0;
    else if (load_inst) ir <= inst_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A decode wins over a same-edge load. The outputs then describe the old
  // word, but they are still a fresh decode, so the state is DECODED.
  always_comb begin
    state_nxt = state;
    if (dec_en)         state_nxt = ST_DECODED;
    else if (load_inst) state_nxt = ST_LOADED;
  end

  assign dec_valid = (state == ST_DECODED);

  always_comb begin
    dec_exec    = EXEC_NONE;
    dec_illegal = 1'b1;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    case (opcode)
      OPC_LOAD:
        if (funct3 == F3_LW) begin
          dec_exec = EXEC_LW; dec_illegal = 1'b0; use_rs1 = 1'b1; use_rd = 1'b1;
        end
      OPC_OP_IMM:
        if (funct3 == F3_SLLI && ir[31:26] == 6'b0) begin
          dec_exec = EXEC_SLLI; dec_illegal = 1'b0; use_rs1 = 1'b1; use_rd = 1'b1;
        end
      OPC_STORE:
        if (funct3 == F3_SW) begin
          dec_exec = EXEC_SW; dec_illegal = 1'b0; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      OPC_BRANCH:
        if (funct3 == F3_BEQ) begin
          dec_exec = EXEC_BEQ; dec_illegal = 1'b0; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_illegal = 1'b0;
          case (funct3)
            F3_ADD_SUB: dec_exec = EXEC_ADD;
            F3_SLL:     dec_exec = EXEC_SLL;
            F3_XOR:     dec_exec = EXEC_XOR;
            F3_OR:      dec_exec = EXEC_OR;
            F3_AND:     dec_exec = EXEC_AND;
            default:    dec_illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          dec_exec = EXEC_SUB; dec_illegal = 1'b0;
        end
        use_rs1 = !dec_illegal;
        use_rs2 = !dec_illegal;
        use_rd  = !dec_illegal;
      end
      OPC_JAL: begin
        dec_exec = EXEC_JAL; dec_illegal = 1'b0; use_rd = 1'b1;
      end
      OPC_SYSTEM:
        if (ir[31:0] == HALT_WORD) begin
          dec_exec = EXEC_HALT; dec_illegal = 1'b0;
        end
      default: ;
    endcase
    if (dec_illegal)
      dec_exec = HALT_ON_ILLEGAL ? EXEC_HALT : EXEC_NONE;
  end

  ms_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir        (ir),
    .imm       (gen_imm),
    .pc_offset (gen_pc_offset)
  );

  // The immediate generator only looks at opcode/funct3, so illegal words
  // such as an SLLI with a nonzero upper shamt field are zeroed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      execution <= EXEC_NONE;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      pc_offset <= '0;
      illegal   <= 1'b0;
    end else if (dec_en) begin
      execution <= dec_exec;
      rs1       <= use_rs1 ? RA_W'(ir[19:15]) : '0;
      rs2       <= use_rs2 ? RA_W'(ir[24:20]) : '0;
      rd        <= use_rd  ? RA_W'(ir[11:7])  : '0;
      imm       <= dec_illegal ? '0 : gen_imm;
      pc_offset <= dec_illegal ? '0 : gen_pc_offset;
      illegal   <= illegal | dec_illegal;
    end
  end

endmodule
